// File: rtl/rv_fetch_unit.sv
// Instruction-fetch front end: credit-limited pipelined imem requests, in-order instruction FIFO,
// redirect flush with stale-response discard. Define FETCH_PERF_EN to add perf counter outputs.
module rv_fetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [ILEN-1:0]  imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [ILEN-1:0]  inst_data,
  output logic [XLEN-1:0]  inst_pc,
  output logic [CNT_W-1:0] fifo_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_flushes,
  output logic [31:0]      perf_discards
`endif
);

  localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0]  DepthSum = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e           state_q, state_d;
  logic             run_q;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]  rpc_wr_q, rpc_rd_q;
  logic             ovf_err_q;

  logic [ILEN-1:0]  data_mem_q [DEPTH];
  logic [XLEN-1:0]  pc_mem_q   [DEPTH];
  logic [XLEN-1:0]  rpc_mem_q  [DEPTH];

  logic             credit_ok;
  logic             req_fire;
  logic             drop_rsp;
  logic             push;
  logic             push_ok;
  logic             overflow;
  logic             pop;
  logic [XLEN-1:0]  rsp_pc;

  // Low address bits of a redirect target are ignored; the overflow flag has no port.
  logic unused_redirect_lsb;
  logic unused_ovf_err;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign unused_ovf_err      = ovf_err_q;

  // run_q holds off the first request until the first edge after reset release.
  assign credit_ok      = ({1'b0, count_q} + {1'b0, inflight_q}) < DepthSum;
  assign imem_req_valid = run_q && credit_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_pc         = rpc_mem_q[rpc_rd_q];

  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRun;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  // FSM next state: discard always tracks the number of stale requests still in flight.
  always_comb begin
    discard_d = discard_q;
    if (redirect_valid) begin
      discard_d = inflight_d;
    end else if (drop_rsp) begin
      discard_d = discard_q - CNT_W'(1);
    end
    state_d = (discard_d != '0) ? StFlush : StRun;
  end

  // FSM outputs: a response arriving with a redirect counts as stale.
  always_comb begin
    drop_rsp = 1'b0;
    unique case (state_q)
      StRun:   drop_rsp = imem_rsp_valid && redirect_valid;
      StFlush: drop_rsp = imem_rsp_valid;
      default: drop_rsp = imem_rsp_valid;
    endcase
  end

  always_comb begin
    push       = imem_rsp_valid && !drop_rsp;
    pop        = inst_valid && inst_ready && !redirect_valid;
    push_ok    = push && ((count_q != DepthCnt) || pop);
    overflow   = push && !push_ok;
    inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    if (redirect_valid) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rpc_wr_q   <= '0;
      rpc_rd_q   <= '0;
      ovf_err_q  <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (redirect_valid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      // The request-PC FIFO is never flushed: stale responses still pop their entry.
      if (req_fire)       rpc_wr_q <= rpc_wr_q + PtrW'(1);
      if (imem_rsp_valid) rpc_rd_q <= rpc_rd_q + PtrW'(1);
      if (overflow)       ovf_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
        rpc_mem_q[i]  <= '0;
      end
    end else begin
      if (push_ok) begin
        data_mem_q[wr_ptr_q] <= imem_rsp_data;
        pc_mem_q[wr_ptr_q]   <= rsp_pc;
      end
      if (req_fire) rpc_mem_q[rpc_wr_q] <= fetch_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, discard_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      if (imem_req_valid && !imem_req_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect_valid && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
      if (drop_rsp && (discard_cnt_q != '1)) begin
        discard_cnt_q <= discard_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flushes      = flush_cnt_q;
  assign perf_discards     = discard_cnt_q;
`endif

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: in-order variable-latency memory model, per-cycle vector
// table for the startup stream, and hand-written sequences for backpressure, redirect and reset.
module tb_rv_fetch_unit;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CNT_W    = 3;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             imem_req_valid;
  logic             imem_req_ready = 1'b0;
  logic [XLEN-1:0]  imem_req_addr;
  logic             imem_rsp_valid = 1'b0;
  logic [ILEN-1:0]  imem_rsp_data = '0;
  logic             redirect_valid = 1'b0;
  logic [XLEN-1:0]  redirect_pc = '0;
  logic             inst_valid;
  logic             inst_ready = 1'b0;
  logic [ILEN-1:0]  inst_data;
  logic [XLEN-1:0]  inst_pc;
  logic [CNT_W-1:0] fifo_count;
`ifdef FETCH_PERF_EN
  logic [31:0]      perf_stall_cycles, perf_flushes, perf_discards;
`endif

  rv_fetch_unit #(
    .XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fifo_count(fifo_count)
`ifdef FETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
    .perf_discards(perf_discards)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] addr;
  } mreq_t;

  typedef struct packed {
    logic        rdy;
    logic        irdy;
    logic        rv;
    logic [63:0] addr;
    logic        iv;
    logic [63:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  mreq_t       mq[$];
  logic [63:0] acc_q[$];
  logic [63:0] dlv_q[$];
  vec_t        vt[8];

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A00_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mem_capture();
    if (imem_req_valid && imem_req_ready) begin
      mreq_t r;
      int    d;
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      r.due  = d;
      r.addr = imem_req_addr;
      mq.push_back(r);
      acc_q.push_back(imem_req_addr);
      last_due = d;
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      dlv_q.push_back(inst_pc);
      check("pair", 64'(inst_data), 64'(word_of(inst_pc)));
    end
  endtask

  task automatic mem_drive();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // Called at a negedge; returns at the negedge of the following cycle.
  task automatic next_cycle();
    #1;
    mem_capture();
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    mem_drive();
    @(negedge clk);
  endtask

  task automatic release_reset();
    mq.delete();
    acc_q.delete();
    dlv_q.delete();
    last_due       = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
    mem_drive();
    @(negedge clk);
  endtask

  task automatic fresh_start();
    reset = 1'b0;
    @(posedge clk);
    release_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          k;
`ifdef FETCH_PERF_EN
    logic [31:0] perf0;
`endif

    vt[0] = '{1'b1, 1'b1, 1'b0, 64'h00, 1'b0, 64'h00, 3'd0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 64'h00, 1'b0, 64'h00, 3'd0};
    vt[2] = '{1'b1, 1'b1, 1'b1, 64'h04, 1'b0, 64'h00, 3'd0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 64'h08, 1'b1, 64'h00, 3'd1};
    vt[4] = '{1'b1, 1'b1, 1'b1, 64'h0C, 1'b1, 64'h04, 3'd1};
    vt[5] = '{1'b1, 1'b1, 1'b1, 64'h10, 1'b1, 64'h08, 3'd1};
    vt[6] = '{1'b1, 1'b1, 1'b1, 64'h14, 1'b1, 64'h0C, 3'd1};
    vt[7] = '{1'b1, 1'b1, 1'b1, 64'h18, 1'b1, 64'h10, 3'd1};

    // Reset state.
    @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_inst_data", 64'(inst_data), 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);

    // Startup stream, latency 1, everything ready.
    lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    release_reset();
    for (int i = 0; i < 8; i++) begin
      check("vec_req_valid", 64'(imem_req_valid), 64'(vt[i].rv));
      check("vec_req_addr", imem_req_addr, vt[i].addr);
      check("vec_inst_valid", 64'(inst_valid), 64'(vt[i].iv));
      check("vec_inst_pc", inst_pc, vt[i].pc);
      check("vec_inst_data", 64'(inst_data), vt[i].iv ? 64'(word_of(vt[i].pc)) : 64'd0);
      check("vec_fifo_count", 64'(fifo_count), 64'(vt[i].cnt));
      imem_req_ready = vt[i].rdy;
      inst_ready     = vt[i].irdy;
      next_cycle();
    end

    // Decode stalled, latency 2: credits cap issue at DEPTH requests.
    lat = 2;
    inst_ready = 1'b0;
    fresh_start();
    repeat (12) next_cycle();
    check("s2_accepts", 64'(acc_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) check("s2_addr", acc_q[i], 64'(4 * i));
    check("s2_fifo_full", 64'(fifo_count), 64'd4);
    check("s2_req_blocked", 64'(imem_req_valid), 64'd0);
    inst_ready = 1'b1;
    for (k = 0; k < 10 && acc_q.size() == 4; k++) next_cycle();
    check("s2_resume_addr", (acc_q.size() > 4) ? acc_q[4] : 64'hDEAD, 64'h10);
    repeat (8) next_cycle();
    check("s2_first_dlv", (dlv_q.size() > 0) ? dlv_q[0] : 64'hDEAD, 64'h0);

    // Redirect with three requests in flight, latency 3.
    lat = 3;
    fresh_start();
    while (cyc < 4) next_cycle();
    check("s3_inflight", 64'(acc_q.size()), 64'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1003;
    #1;
    check("s3_req_off", 64'(imem_req_valid), 64'd0);
    next_cycle();
    dlv_q.delete();
    check("s3_req_valid", 64'(imem_req_valid), 64'd1);
    check("s3_req_addr", imem_req_addr, 64'h1000);
    check("s3_inst_valid", 64'(inst_valid), 64'd0);
    check("s3_fifo_count", 64'(fifo_count), 64'd0);
    repeat (20) next_cycle();
    check("s3_dlv_cnt", 64'(dlv_q.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < dlv_q.size(); i++) check("s3_dlv_pc", dlv_q[i], 64'h1000 + 64'(4 * i));

    // Back-to-back redirects while the 0x1000 stream is in flight.
`ifdef FETCH_PERF_EN
    perf0 = perf_flushes;
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h300;
    #1;
    check("s4_req_off", 64'(imem_req_valid), 64'd0);
    next_cycle();
    dlv_q.delete();
    n = acc_q.size();
    repeat (20) next_cycle();
    check("s4_first_req", (acc_q.size() > n) ? acc_q[n] : 64'hDEAD, 64'h300);
    check("s4_dlv_cnt", 64'(dlv_q.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < dlv_q.size(); i++) check("s4_dlv_pc", dlv_q[i], 64'h300 + 64'(4 * i));
`ifdef FETCH_PERF_EN
    check("s4_perf_flushes", 64'(perf_flushes - perf0), 64'd2);
`endif

    // Memory backpressure holds the request address.
    lat = 1;
    fresh_start();
    for (k = 0; k < 40 && !(imem_req_valid && imem_req_addr == 64'h40); k++) next_cycle();
    check("s5_reach_40", 64'(imem_req_valid && imem_req_addr == 64'h40), 64'd1);
    imem_req_ready = 1'b0;
`ifdef FETCH_PERF_EN
    perf0 = perf_stall_cycles;
`endif
    for (int i = 0; i < 5; i++) begin
      check("s5_hold_addr", imem_req_addr, 64'h40);
      check("s5_hold_valid", 64'(imem_req_valid), 64'd1);
      next_cycle();
    end
`ifdef FETCH_PERF_EN
    check("s5_perf_stall", 64'(perf_stall_cycles - perf0), 64'd5);
`endif
    imem_req_ready = 1'b1;
    check("s5_after_addr", imem_req_addr, 64'h40);
    next_cycle();
    check("s5_next_addr", imem_req_addr, 64'h44);
    check("s5_last_acc", (acc_q.size() > 0) ? acc_q[acc_q.size() - 1] : 64'hDEAD, 64'h40);

    // Asynchronous reset with three buffered entries.
    inst_ready = 1'b0;
    fresh_start();
    for (k = 0; k < 20 && fifo_count != 3'd3; k++) next_cycle();
    check("s6_fill3", 64'(fifo_count), 64'd3);
    reset = 1'b0;
    #1;
    check("s6_inst_valid", 64'(inst_valid), 64'd0);
    check("s6_fifo_count", 64'(fifo_count), 64'd0);
    check("s6_req_valid", 64'(imem_req_valid), 64'd0);
    check("s6_req_addr", imem_req_addr, RESET_PC);
    inst_ready = 1'b1;
    release_reset();
    for (k = 0; k < 10 && dlv_q.size() == 0; k++) next_cycle();
    check("s6_restart_acc", (acc_q.size() > 0) ? acc_q[0] : 64'hDEAD, RESET_PC);
    check("s6_restart_dlv", (dlv_q.size() > 0) ? dlv_q[0] : 64'hDEAD, RESET_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation RISC-V core. It replaces the single-cycle PC register, the +4 adder and the direct instruction-memory read.
- Issues pipelined, in-order requests to a latency-tolerant instruction memory.
- Buffers returned instructions with their PCs in a FIFO.
- Hands instructions to decode through a valid/ready handshake.
- Supports branch/jump redirect with flush, including discard of stale in-flight responses.

Parameters:
XLEN, 64, PC and address width in bits
ILEN, 32, instruction width in bits
RESET_PC, 0, fetch address after reset (XLEN bits)
DEPTH, 4, instruction FIFO entries (power of two, >=2); also the maximum requests in flight plus buffered
CNT_W, 3, width of fill/credit counters (must be >= clog2(DEPTH)+1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  XLEN  fetch address, bits[1:0]=0
imem_rsp_valid  input  1  response valid; responses in request order, latency >=1 cycle
imem_rsp_data  input  ILEN  instruction word
redirect_valid  input  1  branch/jump taken; flush and restart
redirect_pc  input  XLEN  new fetch address; bits[1:0] ignored and forced to 0
inst_valid  output  1  FIFO head valid
inst_ready  input  1  decode consumes head
inst_data  output  ILEN  head instruction
inst_pc  output  XLEN  PC of head instruction
fifo_count  output  CNT_W  current FIFO occupancy

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC. FIFO empty, inflight=0, discard=0. imem_req_valid=0, inst_valid=0, fifo_count=0, inst_data=0, inst_pc=0. imem_req_addr=RESET_PC.
- First request is issued in the first cycle after reset deassertion.
- Credit rule: imem_req_valid=1 iff (fifo_count + inflight) < DEPTH and redirect_valid=0.
- A request is accepted on valid&&ready. On acceptance: inflight+1, fetch_pc += 4, wrapping modulo 2^XLEN.
- imem_req_addr=fetch_pc and stays stable while valid && !ready.
- A separate request-PC FIFO of DEPTH entries records the address of each accepted request. Each response pops it, so inst_pc pairs exactly with inst_data.
- Response with discard==0: push {data, pc} into the FIFO; inflight-1. Overflow cannot occur by the credit rule. If it does, the entry is dropped and the internal sticky error flag is set.
- Response with discard>0: drop the word and its PC entry; discard-1, inflight-1.
- Dequeue on inst_valid&&inst_ready. inst_valid=(fifo_count!=0). inst_data/inst_pc are registered FIFO head outputs.
- Simultaneous push and pop: fifo_count unchanged. When the FIFO is empty, the pushed entry is visible as inst_valid on the next cycle (no bypass). Fetch-to-decode latency = memory latency + 1 cycle.
- Redirect (single-cycle pulse), effective at the clock edge:
  - FIFO flushed (fifo_count=0, inst_valid=0 next cycle). A same-cycle inst_ready pop is ignored.
  - discard=inflight, counting any response arriving that same cycle as already discarded.
  - fetch_pc={redirect_pc[XLEN-1:2],2'b00}.
  - imem_req_valid forced 0 during the redirect cycle.
  - New requests resume the following cycle and are not blocked by discard, because credits still include stale inflight.
- Back-to-back redirects: the latest wins. discard accumulates correctly because it always equals the stale inflight count.
- Internal state machine:
  - RUN: normal operation.
  - FLUSH: discard>0; stale responses are being dropped, while new requests may still issue.
  - Returns to RUN when discard reaches 0.
  - Reset forces RUN.
- Reset mid-operation: all state is cleared immediately. The memory must also be reset, so no stale responses are expected afterwards.

Optional Feature:
FETCH_PERF_EN
- When defined: adds outputs perf_stall_cycles (32 bits, counts cycles with imem_req_valid=1 && imem_req_ready=0), perf_flushes (32 bits, counts redirects) and perf_discards (32 bits, counts dropped responses).
  - All three saturate at 2^32-1 and reset to 0.
- When undefined: these ports and counters are absent. Functional behaviour is identical.

Test Plan:
- Reset release, memory ready always, latency 1, inst_ready=1 -> addresses 0x0,0x4,0x8,... on consecutive cycles. First inst_valid at cycle 3 after reset deassert with inst_pc=0x0. Thereafter one instruction per cycle.
- inst_ready=0, memory latency 2, DEPTH=4 -> exactly 4 requests issued (0x0..0xC). fifo_count reaches 4, imem_req_valid stays 0. Raising inst_ready resumes requests at 0x10.
- Redirect to 0x1003 with 3 requests in flight (latency 3) -> the next request address is 0x1000. The 3 stale responses are dropped and never appear on inst_*. The first inst_pc after the redirect is 0x1000.
- Two redirects on consecutive cycles (0x200, then 0x300) -> no instruction with pc 0x200 or its successors is delivered. The first delivered inst_pc is 0x300.
- imem_req_ready held low 5 cycles at fetch_pc 0x40 -> imem_req_addr stays 0x40 throughout. With FETCH_PERF_EN, perf_stall_cycles increments by exactly 5.
- Reset asserted mid-burst with FIFO holding 3 entries -> inst_valid=0, fifo_count=0 and imem_req_valid=0 immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC.
